// File: rtl/ql_seg_alu.sv
// Segmented, pipelined add/subtract with registered inter-segment carry and valid/ready flow.
// Optional zero/less-than flags are enabled by defining QL_SEG_ALU_FLAGS_EN.
`timescale 1ns/1ps
module ql_seg_alu #(
  parameter int WIDTH     = 32,
  parameter int SEG_WIDTH = 8,
  parameter int A_SIGNED  = 0,
  parameter int B_SIGNED  = 0
) (
  input  logic             CLK,
  input  logic             SRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  input  logic             in_bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [WIDTH-1:0] out_x,
  output logic [WIDTH-1:0] out_co,
  output logic             out_ovf
`ifdef QL_SEG_ALU_FLAGS_EN
  ,
  output logic             out_zero,
  output logic             out_lt
`endif
);

  localparam int NSEG        = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
  localparam bit SIGNED_MODE = (A_SIGNED != 0) && (B_SIGNED != 0);

  logic [NSEG-1:0]            v_q, v_d;
  logic [NSEG-1:0][WIDTH-1:0] a_q, a_d, b_q, b_d, y_q, y_d, co_q, co_d;
  logic [WIDTH-1:0]           x_q, x_d;
  logic                       ovf_q, ovf_d;
`ifdef QL_SEG_ALU_FLAGS_EN
  logic                       zero_q, zero_d, lt_q, lt_d;
`endif
  logic                       adv;

  assign adv      = ~v_q[NSEG-1] | out_ready;
  assign in_ready = adv;

  // Per-stage segment evaluation: stage k resolves bits of segment k, lower bits pass through.
  always_comb begin
    logic             sv, c, cmsb;
    logic [WIDTH-1:0] sa, sb, sy, sco;
    int               km1, cidx, lo, hi;
    v_d    = v_q;
    a_d    = a_q;
    b_d    = b_q;
    y_d    = y_q;
    co_d   = co_q;
    x_d    = x_q;
    ovf_d  = ovf_q;
    sv     = 1'b0;
    c      = 1'b0;
    cmsb   = 1'b0;
    sa     = '0;
    sb     = '0;
    sy     = '0;
    sco    = '0;
    for (int k = 0; k < NSEG; k++) begin
      km1  = (k == 0) ? 0 : k - 1;
      cidx = (k == 0) ? 0 : k * SEG_WIDTH - 1;
      if (k == 0) begin
        sv  = in_valid;
        sa  = in_a;
        sb  = in_bi ? ~in_b : in_b;
        sy  = '0;
        sco = '0;
        c   = in_ci;
      end else begin
        sv  = v_q[km1];
        sa  = a_q[km1];
        sb  = b_q[km1];
        sy  = y_q[km1];
        sco = co_q[km1];
        c   = co_q[km1][cidx];
      end
      cmsb = c;
      lo   = k * SEG_WIDTH;
      hi   = ((k + 1) * SEG_WIDTH < WIDTH) ? (k + 1) * SEG_WIDTH : WIDTH;
      for (int i = lo; i < hi; i++) begin
        cmsb   = (i == WIDTH - 1) ? c : cmsb;
        sy[i]  = sa[i] ^ sb[i] ^ c;
        c      = (sa[i] & sb[i]) | (c & (sa[i] ^ sb[i]));
        sco[i] = c;
      end
      v_d[k]  = adv ? sv : v_q[k];
      a_d[k]  = (adv && sv) ? sa  : a_q[k];
      b_d[k]  = (adv && sv) ? sb  : b_q[k];
      y_d[k]  = (adv && sv) ? sy  : y_q[k];
      co_d[k] = (adv && sv) ? sco : co_q[k];
    end
    // sa/sb/sy/sco/cmsb now hold the last stage's view of the beat.
    x_d   = (adv && sv) ? (sa ^ sb) : x_q;
    ovf_d = (adv && sv) ? (SIGNED_MODE ? (sco[WIDTH-1] ^ cmsb) : sco[WIDTH-1]) : ovf_q;
`ifdef QL_SEG_ALU_FLAGS_EN
    zero_d = (adv && sv) ? (sy == '0) : zero_q;
    lt_d   = (adv && sv) ? (SIGNED_MODE ? (sy[WIDTH-1] ^ sco[WIDTH-1] ^ cmsb) : ~sco[WIDTH-1])
                         : lt_q;
`endif
  end

  // Pipeline state registers with synchronous clear.
  always_ff @(posedge CLK) begin
    if (SRST) begin
      v_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      y_q    <= '0;
      co_q   <= '0;
      x_q    <= '0;
      ovf_q  <= 1'b0;
`ifdef QL_SEG_ALU_FLAGS_EN
      zero_q <= 1'b0;
      lt_q   <= 1'b0;
`endif
    end else begin
      v_q    <= v_d;
      a_q    <= a_d;
      b_q    <= b_d;
      y_q    <= y_d;
      co_q   <= co_d;
      x_q    <= x_d;
      ovf_q  <= ovf_d;
`ifdef QL_SEG_ALU_FLAGS_EN
      zero_q <= zero_d;
      lt_q   <= lt_d;
`endif
    end
  end

  assign out_valid = v_q[NSEG-1];
  assign out_y     = y_q[NSEG-1];
  assign out_co    = co_q[NSEG-1];
  assign out_x     = x_q;
  assign out_ovf   = ovf_q;
`ifdef QL_SEG_ALU_FLAGS_EN
  assign out_zero  = zero_q;
  assign out_lt    = lt_q;
`endif

endmodule

// File: tb/tb_ql_seg_alu.sv
// Bench for ql_seg_alu: directed vectors on 32/8 (unsigned and signed) and 10/4 instances,
// random streams against an arithmetic reference model, and a mid-flight reset.
`timescale 1ns/1ps
module tb_ql_seg_alu;

  logic        CLK = 1'b0;
  logic        SRST;
  logic        in_valid, in_valid10, in_ci, in_bi, out_ready;
  logic [31:0] in_a, in_b;

  logic        in_ready_u, out_valid_u, out_ovf_u;
  logic [31:0] out_y_u, out_x_u, out_co_u;
  logic        in_ready_s, out_valid_s, out_ovf_s;
  logic [31:0] out_y_s, out_x_s, out_co_s;
  logic        in_ready_t, out_valid_t, out_ovf_t;
  logic [9:0]  out_y_t, out_x_t, out_co_t;
`ifdef QL_SEG_ALU_FLAGS_EN
  logic        out_zero_u, out_lt_u, out_zero_s, out_lt_s, out_zero_t, out_lt_t;
`endif

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ql_seg_alu #(.WIDTH(32), .SEG_WIDTH(8), .A_SIGNED(0), .B_SIGNED(0)) u_u32 (
    .CLK(CLK), .SRST(SRST), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .in_bi(in_bi),
    .out_valid(out_valid_u), .out_ready(out_ready), .out_y(out_y_u), .out_x(out_x_u),
    .out_co(out_co_u), .out_ovf(out_ovf_u)
`ifdef QL_SEG_ALU_FLAGS_EN
    , .out_zero(out_zero_u), .out_lt(out_lt_u)
`endif
  );

  ql_seg_alu #(.WIDTH(32), .SEG_WIDTH(8), .A_SIGNED(1), .B_SIGNED(1)) u_s32 (
    .CLK(CLK), .SRST(SRST), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci), .in_bi(in_bi),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_y(out_y_s), .out_x(out_x_s),
    .out_co(out_co_s), .out_ovf(out_ovf_s)
`ifdef QL_SEG_ALU_FLAGS_EN
    , .out_zero(out_zero_s), .out_lt(out_lt_s)
`endif
  );

  ql_seg_alu #(.WIDTH(10), .SEG_WIDTH(4), .A_SIGNED(0), .B_SIGNED(0)) u_t10 (
    .CLK(CLK), .SRST(SRST), .in_valid(in_valid10), .in_ready(in_ready_t),
    .in_a(in_a[9:0]), .in_b(in_b[9:0]), .in_ci(in_ci), .in_bi(in_bi),
    .out_valid(out_valid_t), .out_ready(out_ready), .out_y(out_y_t), .out_x(out_x_t),
    .out_co(out_co_t), .out_ovf(out_ovf_t)
`ifdef QL_SEG_ALU_FLAGS_EN
    , .out_zero(out_zero_t), .out_lt(out_lt_t)
`endif
  );

  typedef struct packed {
    logic [31:0] y, x, co;
    logic        ou, os, zero, ltu, lts, sub;
  } res_t;

  typedef struct {
    logic [31:0] a, b;
    logic        ci, bi;
    logic [31:0] y, x, co;
    logic        ou, os;
    logic [9:0]  y10, x10, co10;
    logic        o10;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Arithmetic reference: whole-word sums at width w, carries from prefix sums.
  function automatic res_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci, input logic bi);
    res_t r;
    longint unsigned m, aa, bb, s, t, mi, ua, ub;
    longint sa_l, sb_l;
    r  = '0;
    m  = (64'd1 << w) - 64'd1;
    ua = {32'd0, a} & m;
    ub = {32'd0, b} & m;
    aa = ua;
    bb = {32'd0, (bi ? ~b : b)} & m;
    s  = aa + bb + {63'd0, ci};
    r.y = 32'(s & m);
    r.x = 32'(aa ^ bb);
    for (int i = 0; i < w; i++) begin
      mi = (64'd1 << (i + 1)) - 64'd1;
      t  = (aa & mi) + (bb & mi) + {63'd0, ci};
      r.co[i] = t[i+1];
    end
    r.ou   = s[w];
    r.os   = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
    r.zero = ((s & m) == 64'd0);
    r.ltu  = ua < ub;
    sa_l   = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb_l   = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    r.lts  = sa_l < sb_l;
    r.sub  = bi & ci;
    return r;
  endfunction

  task automatic check_flags(input string tag, input res_t e);
`ifdef QL_SEG_ALU_FLAGS_EN
    chk({tag, "_zero_u"}, {31'd0, out_zero_u}, {31'd0, e.zero});
    chk({tag, "_zero_s"}, {31'd0, out_zero_s}, {31'd0, e.zero});
    if (e.sub) begin
      chk({tag, "_lt_u"}, {31'd0, out_lt_u}, {31'd0, e.ltu});
      chk({tag, "_lt_s"}, {31'd0, out_lt_s}, {31'd0, e.lts});
    end
`else
    if (e.sub && tag.len() == 0) $display("note: empty tag");
`endif
  endtask

  // One isolated beat through all three instances; checks latency and outputs.
  task automatic run_vec(input vec_t v, input string tag);
    int   lat32, lat10;
    res_t e;
    e = model(32, v.a, v.b, v.ci, v.bi);
    in_a = v.a; in_b = v.b; in_ci = v.ci; in_bi = v.bi;
    in_valid = 1'b1; in_valid10 = 1'b1; out_ready = 1'b1;
    @(posedge CLK); #1;
    in_valid = 1'b0; in_valid10 = 1'b0;
    lat32 = 0; lat10 = 0;
    for (int c = 1; c <= 8; c++) begin
      if (out_valid_u && lat32 == 0) begin
        lat32 = c;
        chk({tag, "_y32"},   out_y_u,  v.y);
        chk({tag, "_x32"},   out_x_u,  v.x);
        chk({tag, "_co32"},  out_co_u, v.co);
        chk({tag, "_ovfu"},  {31'd0, out_ovf_u}, {31'd0, v.ou});
        chk({tag, "_ovfs"},  {31'd0, out_ovf_s}, {31'd0, v.os});
        chk({tag, "_ys32"},  out_y_s,  v.y);
        check_flags(tag, e);
      end
      if (out_valid_t && lat10 == 0) begin
        lat10 = c;
        chk({tag, "_y10"},   {22'd0, out_y_t},  {22'd0, v.y10});
        chk({tag, "_x10"},   {22'd0, out_x_t},  {22'd0, v.x10});
        chk({tag, "_co10"},  {22'd0, out_co_t}, {22'd0, v.co10});
        chk({tag, "_ovf10"}, {31'd0, out_ovf_t}, {31'd0, v.o10});
      end
      @(posedge CLK); #1;
    end
    chk({tag, "_lat32"}, lat32, 32'd4);
    chk({tag, "_lat10"}, lat10, 32'd3);
  endtask

  // Random stream on the 32-bit pair; expected results queued in acceptance order.
  task automatic run_stream(input int n, input bit rand_mode, input string tag);
    res_t q[$];
    int   sent, got, cyc;
    bit   have;
    sent = 0; got = 0; cyc = 0; have = 1'b0;
    in_valid10 = 1'b0;
    while (got < n && cyc < 2000) begin
      out_ready = rand_mode ? 1'($urandom_range(0, 1)) : ((cyc % 2) == 0);
      if (!have && sent < n && (!rand_mode || $urandom_range(0, 3) != 0)) begin
        in_a  = $urandom;
        in_b  = ($urandom_range(0, 3) == 0) ? in_a : $urandom;
        in_ci = 1'($urandom_range(0, 1));
        in_bi = 1'($urandom_range(0, 1));
        have  = 1'b1;
      end
      in_valid = have;
      #1;
      if (out_valid_u) begin
        if (q.size() == 0) begin
          chk({tag, "_spurious"}, 32'd1, 32'd0);
        end else begin
          chk({tag, "_y"},    out_y_u,  q[0].y);
          chk({tag, "_x"},    out_x_u,  q[0].x);
          chk({tag, "_co"},   out_co_u, q[0].co);
          chk({tag, "_ovfu"}, {31'd0, out_ovf_u}, {31'd0, q[0].ou});
          chk({tag, "_ys"},   out_y_s,  q[0].y);
          chk({tag, "_ovfs"}, {31'd0, out_ovf_s}, {31'd0, q[0].os});
          check_flags(tag, q[0]);
        end
        if (out_ready) begin
          got++;
          if (q.size() != 0) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready_u) begin
        q.push_back(model(32, in_a, in_b, in_ci, in_bi));
        sent++;
        have = 1'b0;
      end
      cyc++;
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    chk({tag, "_count"}, got, n);
    chk({tag, "_left"}, q.size(), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int flush_valid;
    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_00FE,
                32'h0000_00FF, 1'b0, 1'b0, 10'h100, 10'h0FE, 10'h0FF, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFE,
                32'hFFFF_FFFF, 1'b1, 1'b0, 10'h000, 10'h3FE, 10'h3FF, 1'b1};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFE,
                32'h8000_0000, 1'b1, 1'b1, 10'h3FF, 10'h3FE, 10'h000, 1'b0};
    vecs[3] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0002, 32'hFFFF_FFF9,
                32'hFFFF_FFFD, 1'b1, 1'b0, 10'h002, 10'h3F9, 10'h3FD, 1'b1};
    vecs[4] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFE,
                32'h7FFF_FFFF, 1'b0, 1'b1, 10'h000, 10'h3FE, 10'h3FF, 1'b1};

    SRST = 1'b1; in_valid = 1'b0; in_valid10 = 1'b0; in_ci = 1'b0; in_bi = 1'b0;
    in_a = 32'd0; in_b = 32'd0; out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    SRST = 1'b0;
    #1;
    chk("rst_valid_u", {31'd0, out_valid_u}, 32'd0);
    chk("rst_valid_t", {31'd0, out_valid_t}, 32'd0);
    chk("rst_ready_u", {31'd0, in_ready_u}, 32'd1);
    chk("rst_ready_t", {31'd0, in_ready_t}, 32'd1);
    chk("rst_y_u", out_y_u, 32'd0);
    chk("rst_co_u", out_co_u, 32'd0);
    chk("rst_ovf_u", {31'd0, out_ovf_u}, 32'd0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    run_stream(16, 1'b0, "stream_toggle");
    run_stream(40, 1'b1, "stream_rand");

    // Three beats in flight, then reset with a fourth beat presented.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_a = 32'h10 + 32'(i); in_b = 32'h1; in_ci = 1'b0; in_bi = 1'b0; in_valid = 1'b1;
      @(posedge CLK); #1;
    end
    SRST = 1'b1; in_a = 32'h55;
    @(posedge CLK); #1;
    SRST = 1'b0; in_valid = 1'b0;
    chk("srst_valid", {31'd0, out_valid_u}, 32'd0);
    chk("srst_ready", {31'd0, in_ready_u}, 32'd1);
    chk("srst_y", out_y_u, 32'd0);
    flush_valid = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK); #1;
      if (out_valid_u) flush_valid++;
    end
    chk("srst_flushed", flush_valid, 32'd0);
    run_vec(vecs[1], "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
